// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line rate constants,
// and the clock-divider computation used by both receive and transmit sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    localparam int unsigned UART_CLK_FREQ  = 100000000;
    localparam int unsigned UART_BAUD      = 115200;
    localparam int unsigned UART_OVERSAMPLE = 16;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running down-counter that pulses tick for
// one cycle at zero. restart reloads it so tick phase follows an event.
module uart_baud_tick #(
    parameter int unsigned DIV = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on restart or wrap, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: 2-flop synchroniser, oversampled mid-bit sampling,
// framing-error detection and break suppression via WAIT_IDLE.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
    parameter int unsigned BAUD       = UART_BAUD,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_dataout,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rxbusy
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [1:0]           sync_q;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q;
    logic                 rx_s;
    logic                 restart;
    logic                 tick;

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state and datapath decisions; sampling happens only on ticks.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        b_cnt_d = b_cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                    restart = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt_q == S_HALF) begin
                        s_cnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            b_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (b_cnt_q == B_LAST) begin
                            state_d = STOP;
                        end else begin
                            b_cnt_d = b_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        data_d  = shreg_q;
                        if (rx_s) begin
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold here through a break so a low line cannot start frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            s_cnt_q <= '0;
            b_cnt_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx_in};
            s_cnt_q <= s_cnt_d;
            b_cnt_q <= b_cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign rx_dataout   = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rxbusy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm. The line rate is raised so one bit is
// 64 clocks (DIV=4) to keep the run short; all timing windows scale with BIT.
module tb_uart_rx_fsm;

    localparam int unsigned CLK_FREQ = 100000000;
    localparam int unsigned BAUD     = 1562500;
    localparam int unsigned OS       = 16;
    localparam int          DIVV     = CLK_FREQ / (BAUD * OS);
    localparam int          BIT      = OS * DIVV;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_dataout;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rxbusy;

    int checks   = 0;
    int failures = 0;

    // Monitor state: what the DUT actually produced.
    int         vcnt      = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         busy_cyc  = 0;
    int         cyc       = 0;
    int         valid_cyc = 0;
    logic [7:0] rxq[$];

    uart_rx_fsm #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .rx_dataout   (rx_dataout),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rxbusy       (rxbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                vcnt      <= vcnt + 1;
                valid_cyc <= cyc;
                rxq.push_back(rx_dataout);
            end
            if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
            if (rx_valid && rx_frame_err) both_cnt <= both_cnt + 1;
            if (rxbusy) busy_cyc <= busy_cyc + 1;
        end
    end

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset;
        rx_in = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_dataout !== 8'h00) begin
            failures++; $display("FAIL reset_data got=%h want=00", rx_dataout);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
            failures++; $display("FAIL reset_pulses got v=%b fe=%b want 0 0", rx_valid, rx_frame_err);
        end
        checks++;
        if (rxbusy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", rxbusy);
        end
        reset = 1'b1;
        repeat (2000) @(negedge clk);
        checks++;
        if (vcnt != 0 || ferr_cnt != 0 || busy_cyc != 0) begin
            failures++;
            $display("FAIL idle_quiet got v=%0d fe=%0d busy=%0d want 0 0 0", vcnt, ferr_cnt, busy_cyc);
        end
    endtask

    task automatic test_single;
        int v0, f0, b0, t0, lat;
        v0 = vcnt; f0 = ferr_cnt; b0 = busy_cyc;
        rxq.delete();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (BIT) @(negedge clk);
        checks++;
        if (vcnt - v0 != 1 || rxq.size() != 1) begin
            failures++; $display("FAIL single_count got=%0d want=1", vcnt - v0);
        end else begin
            checks++;
            if (rxq[0] !== 8'hA5) begin
                failures++; $display("FAIL single_data got=%h want=a5", rxq[0]);
            end
        end
        checks++;
        if (ferr_cnt != f0) begin
            failures++; $display("FAIL single_ferr got=%0d want=0", ferr_cnt - f0);
        end
        // Valid expected near mid stop bit: 2 sync cycles + 9.5 bits.
        lat = valid_cyc - t0;
        checks++;
        if (lat < 2 + (19 * BIT) / 2 - 3 * DIVV || lat > 2 + (19 * BIT) / 2 + 3 * DIVV) begin
            failures++; $display("FAIL single_latency got=%0d want~%0d", lat, 2 + (19 * BIT) / 2);
        end
        checks++;
        if (busy_cyc - b0 < 8 * BIT || busy_cyc - b0 > 10 * BIT) begin
            failures++; $display("FAIL single_busy_len got=%0d want %0d..%0d", busy_cyc - b0, 8 * BIT, 10 * BIT);
        end
        checks++;
        if (rxbusy !== 1'b0) begin
            failures++; $display("FAIL single_busy_end got=%b want=0", rxbusy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int v0, f0, bad;
        v0 = vcnt; f0 = ferr_cnt; bad = 0;
        rxq.delete();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (vcnt - v0 != 20 || rxq.size() != 20) begin
            failures++; $display("FAIL b2b_count got=%0d want=20", vcnt - v0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rxq[i] !== exp_q[i]) begin
                    failures++; bad++;
                    $display("FAIL b2b_data[%0d] got=%h want=%h", i, rxq[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ferr_cnt != f0) begin
            failures++; $display("FAIL b2b_ferr got=%0d want=0", ferr_cnt - f0);
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = vcnt; f0 = ferr_cnt;
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (rxbusy !== 1'b1) begin
            failures++; $display("FAIL glitch_busy_rise got=%b want=1", rxbusy);
        end
        repeat (BIT / 3 - 10) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checks++;
        if (rxbusy !== 1'b0) begin
            failures++; $display("FAIL glitch_busy_fall got=%b want=0", rxbusy);
        end
        checks++;
        if (vcnt != v0 || ferr_cnt != f0) begin
            failures++; $display("FAIL glitch_pulse got v=%0d fe=%0d want 0 0", vcnt - v0, ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = vcnt; f0 = ferr_cnt;
        rxq.delete();
        send_frame(8'h3C, 1'b0);
        rx_in = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        checks++;
        if (ferr_cnt - f0 != 1 || vcnt != v0) begin
            failures++; $display("FAIL ferr_pulse got fe=%0d v=%0d want 1 0", ferr_cnt - f0, vcnt - v0);
        end
        checks++;
        if (rx_dataout !== 8'h3C) begin
            failures++; $display("FAIL ferr_data got=%h want=3c", rx_dataout);
        end
        checks++;
        if (rxbusy !== 1'b1) begin
            failures++; $display("FAIL ferr_break_busy got=%b want=1", rxbusy);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h81, 1'b1);
        repeat (BIT) @(negedge clk);
        checks++;
        if (vcnt - v0 != 1 || rxq.size() != 1 || ferr_cnt - f0 != 1) begin
            failures++; $display("FAIL ferr_recover got v=%0d fe=%0d want 1 1", vcnt - v0, ferr_cnt - f0);
        end else begin
            checks++;
            if (rxq[0] !== 8'h81) begin
                failures++; $display("FAIL ferr_recover_data got=%h want=81", rxq[0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        v0 = vcnt; f0 = ferr_cnt;
        rxq.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_in = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        checks++;
        if (vcnt != v0 || ferr_cnt != f0) begin
            failures++; $display("FAIL abort_pulse got v=%0d fe=%0d want 0 0", vcnt - v0, ferr_cnt - f0);
        end
        checks++;
        if (rx_dataout !== 8'h00 || rxbusy !== 1'b0) begin
            failures++; $display("FAIL abort_state got data=%h busy=%b want 00 0", rx_dataout, rxbusy);
        end
        send_frame(8'h0F, 1'b1);
        repeat (BIT) @(negedge clk);
        checks++;
        if (vcnt - v0 != 1 || rxq.size() != 1) begin
            failures++; $display("FAIL abort_next_count got=%0d want=1", vcnt - v0);
        end else begin
            checks++;
            if (rxq[0] !== 8'h0F) begin
                failures++; $display("FAIL abort_next_data got=%h want=0f", rxq[0]);
            end
        end
    endtask

    initial begin
        rx_in = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        checks++;
        if (both_cnt != 0) begin
            failures++; $display("FAIL valid_ferr_overlap got=%0d want=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
